// File: rtl/vga_square_pkg.sv
// Shared constants, FSM encoding and pixel record for the square/clear VGA controller.
package vga_square_pkg;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int SQ_SIZE      = 4;
    localparam int CLEAR_PIXELS = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef enum logic {
        SEL_X = 1'b0,
        SEL_Y = 1'b1
    } sel_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pix_t;

endpackage

// File: rtl/key_edge_detect.sv
// One-bit registered rising-edge detector; a held level yields a single one-cycle pulse.
module key_edge_detect (
    input  logic clock,
    input  logic resetn,
    input  logic level,
    output logic rise
);

    logic prev;

    // History clears to 0, so a level already high at reset release counts as an edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= level;
            rise <= level & ~prev;
        end
    end

endmodule

// File: rtl/vga_square_ctrl.sv
// Draws a 4x4 square at a stored (x,y) or clears the whole screen, one pixel per cycle to a vga_adapter.
module vga_square_ctrl #(
    parameter int SCREEN_W = vga_square_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_square_pkg::SCREEN_H,
    parameter int SQ_SIZE  = vga_square_pkg::SQ_SIZE
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [6:0] pos_in,
    input  logic [2:0] colour_in,
    input  logic       store_pos,
    input  logic       plot,
    input  logic       clear_scr,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy
);

    import vga_square_pkg::*;

    localparam int         PIX_W    = $clog2(SCREEN_W * SCREEN_H);
    localparam logic [3:0] CNT_LAST = 4'(SQ_SIZE * SQ_SIZE - 1);
    localparam logic [PIX_W-1:0] CLR_LAST = PIX_W'(SCREEN_W * SCREEN_H - 1);
    localparam logic [7:0] X_LAST   = 8'(SCREEN_W - 1);
    localparam logic [7:0] H_LIM    = 8'(SCREEN_H);

    // Command order in the vector: [0]=store_pos, [1]=plot, [2]=clear_scr.
    logic [2:0] cmd_lvl;
    logic [2:0] cmd_evt;
    logic       store_evt, plot_evt, clr_evt;

    assign cmd_lvl = {clear_scr, plot, store_pos};

    key_edge_detect u_key [2:0] (
        .clock  (clock),
        .resetn (resetn),
        .level  (cmd_lvl),
        .rise   (cmd_evt)
    );

    assign store_evt = cmd_evt[0];
    assign plot_evt  = cmd_evt[1];
    assign clr_evt   = cmd_evt[2];

    state_t           state;
    sel_t             sel;
    logic [7:0]       x_reg;
    logic [6:0]       y_reg;
    logic [3:0]       c;
    logic [PIX_W-1:0] pix_cnt;

    // Square pixel to be presented at the next edge: pixel 0 leaves IDLE, c+1 while drawing.
    logic [3:0] c_nxt;
    logic [7:0] sq_x;
    logic [7:0] sq_y;
    logic       sq_vis;

    always_comb begin
        c_nxt  = (state == ST_IDLE) ? 4'd0 : c + 4'd1;
        sq_x   = x_reg + {6'd0, c_nxt[1:0]};
        sq_y   = {1'b0, y_reg} + {6'd0, c_nxt[3:2]};
        sq_vis = (sq_y < H_LIM);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            sel     <= SEL_X;
            x_reg   <= '0;
            y_reg   <= '0;
            c       <= '0;
            pix_cnt <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    writeEn <= 1'b0;
                    busy    <= 1'b0;
                    if (clr_evt) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        writeEn <= 1'b1;
                        pix_cnt <= '0;
                        x       <= '0;
                        y       <= '0;
                        colour  <= 3'b000;
                    end else if (plot_evt) begin
                        state   <= ST_DRAW;
                        busy    <= 1'b1;
                        sel     <= SEL_X;
                        c       <= c_nxt;
                        colour  <= colour_in;
                        x       <= sq_x;
                        y       <= sq_y[6:0];
                        writeEn <= sq_vis;
                    end else if (store_evt) begin
                        if (sel == SEL_X) begin
                            x_reg <= {1'b0, pos_in};
                            sel   <= SEL_Y;
                        end else begin
                            y_reg <= pos_in;
                            sel   <= SEL_X;
                        end
                    end
                end

                ST_DRAW: begin
                    if (c == CNT_LAST) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        writeEn <= 1'b0;
                        c       <= '0;
                    end else begin
                        // Off-screen rows still consume a cycle so DRAW length is fixed.
                        c       <= c_nxt;
                        x       <= sq_x;
                        y       <= sq_y[6:0];
                        writeEn <= sq_vis;
                    end
                end

                ST_CLEAR: begin
                    if (pix_cnt == CLR_LAST) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        writeEn <= 1'b0;
                        pix_cnt <= '0;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 7'd1;
                        end else begin
                            x <= x + 8'd1;
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    writeEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_square_ctrl.sv
// Directed bench for vga_square_ctrl: expected pixels queued at stimulus time, popped on each write.
module tb_vga_square_ctrl;

    import vga_square_pkg::*;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [6:0] pos_in = '0;
    logic [2:0] colour_in = '0;
    logic       store_pos = 1'b0;
    logic       plot = 1'b0;
    logic       clear_scr = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];

    always #10 clock = ~clock;

    vga_square_ctrl dut (
        .clock     (clock),
        .resetn    (resetn),
        .pos_in    (pos_in),
        .colour_in (colour_in),
        .store_pos (store_pos),
        .plot      (plot),
        .clear_scr (clear_scr),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .writeEn   (writeEn),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every write must match the head of the queue; a write with nothing queued is an error.
    always @(negedge clock) begin
        if (writeEn === 1'b1) begin
            chk("write_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk("pixel", {14'd0, x, y, colour}, {14'd0, e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic push_square(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] col);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] px;
            logic [7:0] py;
            px = x0 + 8'(k % 4);
            py = {1'b0, y0} + 8'(k / 4);
            if (py < 8'(SCREEN_H)) exp_q.push_back({px, py[6:0], col});
        end
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({8'(i % SCREEN_W), 7'(i / SCREEN_W), 3'b000});
    endtask

    task automatic store(input logic [6:0] p);
        pos_in = p;
        store_pos = 1'b1;
        tick(3);
        store_pos = 1'b0;
        tick(2);
    endtask

    task automatic wait_done(input int start, input int exp_cycles, input string tag);
        int n;
        int t;
        n = start;
        t = 0;
        while (busy !== 1'b1 && t < 10) begin
            tick(1);
            t++;
        end
        while (busy === 1'b1 && n < 30000) begin
            n++;
            tick(1);
        end
        chk({tag, "_busy_cycles"}, n, exp_cycles);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
        chk({tag, "_wren_low"}, {31'd0, writeEn}, 0);
    endtask

    task automatic plot_sq(input logic [2:0] col, input string tag);
        colour_in = col;
        plot = 1'b1;
        wait_done(0, 16, tag);
        plot = 1'b0;
        tick(2);
    endtask

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int t;

        // Reset state
        tick(3);
        chk("rst_x", {24'd0, x}, 0);
        chk("rst_y", {25'd0, y}, 0);
        chk("rst_colour", {29'd0, colour}, 0);
        chk("rst_wren", {31'd0, writeEn}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        resetn = 1'b1;
        tick(2);

        // Basic square at (10,20), colour 4
        store(7'd10);
        store(7'd20);
        push_square(8'd10, 7'd20, 3'b100);
        plot_sq(3'b100, "sq_basic");
        chk("idle_hold_x", {24'd0, x}, 13);
        chk("idle_hold_y", {25'd0, y}, 23);
        chk("idle_hold_colour", {29'd0, colour}, 4);

        // Bottom edge: rows 120..121 suppressed, DRAW still 16 cycles
        store(7'd127);
        store(7'd118);
        push_square(8'd127, 7'd118, 3'b010);
        plot_sq(3'b010, "sq_bottom");

        // Full clear
        push_clear(CLEAR_PIXELS);
        clear_scr = 1'b1;
        wait_done(0, CLEAR_PIXELS, "clear");
        clear_scr = 1'b0;
        chk("clear_last_x", {24'd0, x}, 159);
        chk("clear_last_y", {25'd0, y}, 119);
        chk("clear_colour", {29'd0, colour}, 0);
        tick(2);

        // plot and clear together: clear wins; plot during CLEAR ignored
        push_clear(CLEAR_PIXELS);
        plot = 1'b1;
        clear_scr = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b1) n++;
            if (i == 3) begin
                plot = 1'b0;
                clear_scr = 1'b0;
            end
            if (i == 100) plot = 1'b1;
            if (i == 104) plot = 1'b0;
            tick(1);
        end
        wait_done(n, CLEAR_PIXELS, "clr_prio");
        tick(20);
        chk("no_square_after_clear", {31'd0, busy}, 0);

        // Reset at pixel 5000 of CLEAR; store_pos high across release
        push_clear(5000);
        clear_scr = 1'b1;
        t = 0;
        while (exp_q.size() > 0 && t < 6000) begin
            tick(1);
            t++;
            if (t == 3) clear_scr = 1'b0;
        end
        chk("rst_mid_reached", exp_q.size(), 0);
        resetn = 1'b0;
        pos_in = 7'd30;
        store_pos = 1'b1;
        #1;
        chk("midrst_wren", {31'd0, writeEn}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_x", {24'd0, x}, 0);
        chk("midrst_y", {25'd0, y}, 0);
        chk("midrst_colour", {29'd0, colour}, 0);
        tick(3);
        chk("midrst_wren_held", {31'd0, writeEn}, 0);
        resetn = 1'b1;
        tick(3);
        store_pos = 1'b0;
        tick(2);
        store(7'd40);
        push_square(8'd30, 7'd40, 3'b111);
        plot_sq(3'b111, "after_rst");

        // Held store: only one X update despite pos_in changing
        pos_in = 7'd50;
        store_pos = 1'b1;
        tick(50);
        pos_in = 7'd99;
        tick(50);
        store_pos = 1'b0;
        tick(2);
        store(7'd60);
        push_square(8'd50, 7'd60, 3'b101);
        plot_sq(3'b101, "held_store");

        // plot beats store in the same cycle
        pos_in = 7'd5;
        colour_in = 3'b001;
        push_square(8'd50, 7'd60, 3'b001);
        store_pos = 1'b1;
        plot = 1'b1;
        wait_done(0, 16, "plot_over_store");
        store_pos = 1'b0;
        plot = 1'b0;
        tick(2);

        // After a plot the next store targets X
        store(7'd12);
        push_square(8'd12, 7'd60, 3'b011);
        plot_sq(3'b011, "plot_after_x");
        store(7'd33);
        store(7'd44);
        push_square(8'd33, 7'd44, 3'b110);
        plot_sq(3'b110, "sel_after_plot");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_square_ctrl.md
VGA_SQUARE_CTRL -- requirements
Module: vga_square_ctrl

Interface
REQ-001 Parameters SHALL be: SCREEN_W default 160, horizontal pixel count; SCREEN_H default 120, vertical pixel count; SQ_SIZE default 4, square edge length in pixels.
REQ-002 clock  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 pos_in  input  7  X or Y coordinate to be stored.
REQ-005 colour_in  input  3  RGB colour for the square.
REQ-006 store_pos  input  1  level, active-high; a rising edge stores pos_in.
REQ-007 plot  input  1  level, active-high; a rising edge draws the square.
REQ-008 clear_scr  input  1  level, active-high; a rising edge clears the screen to black.
REQ-009 x  output  8  pixel column to the vga_adapter.
REQ-010 y  output  7  pixel row to the vga_adapter.
REQ-011 colour  output  3  pixel colour to the vga_adapter.
REQ-012 writeEn  output  1  pixel write strobe to the vga_adapter.
REQ-013 busy  output  1  high while in the DRAW or CLEAR state.

Function
REQ-014 Each command input SHALL pass through a 1-cycle registered rising-edge detector; held levels SHALL produce one event only.
REQ-015 FSM states SHALL be IDLE, DRAW and CLEAR; only IDLE accepts events.
REQ-016 Events arriving in DRAW or CLEAR SHALL be discarded, not queued.
REQ-017 Simultaneous events in IDLE SHALL be prioritised clear_scr > plot > store_pos; lower-priority events SHALL be discarded.
REQ-018 Store events SHALL alternate targets starting with X: pos_in is zero-extended into x_reg[7:0], then the next store event writes y_reg[6:0]; a sel toggle tracks the target.
REQ-019 A plot event SHALL latch colour_in and enter DRAW; the next store event after a plot SHALL target X.
REQ-020 DRAW SHALL run a 4-bit counter c from 0 to 15, one pixel per cycle: x = x_reg + c[1:0], y = y_reg + c[3:2], with the sum computed 8 bits wide.
REQ-021 Pixels with a computed y >= SCREEN_H SHALL keep writeEn low, but the counter SHALL still advance, so DRAW always lasts exactly 16 cycles.
REQ-022 CLEAR SHALL emit SCREEN_W*SCREEN_H = 19200 pixels in row-major order with x as the inner loop, from (0,0) to (159,119), with colour 3'b000 and writeEn high every cycle.
REQ-023 x, y, colour and writeEn SHALL be registered; the first pixel SHALL appear in the cycle after the clock edge at which the edge detector flags the event.
REQ-024 After the last pixel, writeEn and busy SHALL fall in the next cycle and the FSM SHALL return to IDLE.
REQ-025 In IDLE, writeEn SHALL be 0, and x, y and colour SHALL hold their last values.

Reset
REQ-026 When resetn is low, state SHALL be IDLE; x_reg, y_reg, x, y, colour and counters SHALL be 0; sel SHALL be X; writeEn and busy SHALL be 0; edge-detector history SHALL be 0.
REQ-027 Reset asserted mid-DRAW or mid-CLEAR SHALL abort the operation immediately, with no further writeEn pulses.
REQ-028 A command input already high when resetn is released SHALL register as a rising edge on the first clock edge.

Structure
REQ-029 Package vga_square_pkg SHALL hold SCREEN_W, SCREEN_H, SQ_SIZE, the FSM state encoding and the CLEAR pixel count.
REQ-030 One sub-module, key_edge_detect (1-bit registered rising-edge detector), SHALL be instantiated once per command input.
REQ-031 The datapath (coordinate registers, counters, output registers) and the FSM SHALL stay inside vga_square_ctrl.

Verification
REQ-032 store_pos pulse with pos_in=10, store_pos pulse with pos_in=20, then plot with colour_in=3'b100 -> 16 writeEn cycles covering x 10..13 and y 20..23 in order (10,20),(11,20)...(13,23), all colour 4; busy high for exactly 16 cycles.
REQ-033 Store x=127, y=118, then plot -> x spans 127..130; writes occur for y=118 and y=119 only (8 pixels); writeEn stays low for the 8 pixels with y>=120; DRAW lasts 16 cycles.
REQ-034 clear_scr pulse -> 19200 consecutive writes with colour 0; last pixel is (159,119); busy falls 1 cycle after the last write.
REQ-035 plot and clear_scr rising in the same cycle -> CLEAR executes; no square is drawn; a plot pulsed during CLEAR is ignored.
REQ-036 resetn pulsed low at pixel 5000 of CLEAR -> writeEn is 0 immediately; all outputs are 0; the next store event targets X.
REQ-037 store_pos held high for 100 cycles -> x_reg is updated once; sel toggles once.
